// File: rtl/global_branch_predictor.sv
// Global-history branch direction predictor.
// A shift register of recent resolved outcomes (GHR) directly indexes a table
// of 2-bit saturating counters (PHT). The counter MSB at the current GHR is the
// prediction. Training updates the counter at the old GHR and shifts the new
// outcome into the GHR on the same edge.
module global_branch_predictor #(
  parameter int HIST_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic branch,
  input  logic update,
  output logic prediction
);

  localparam int DEPTH = 1 << HIST_BITS;

  logic [HIST_BITS-1:0] ghr_reg;
  logic [HIST_BITS-1:0] ghr_next;
  logic [1:0]           pht_reg [DEPTH];
  logic [1:0]           cnt_cur;
  logic [1:0]           cnt_next;

  // The counter selected by the current history drives both the prediction
  // and the training write, so they always refer to the same entry.
  assign cnt_cur    = pht_reg[ghr_reg];
  assign prediction = cnt_cur[1];

  // Saturating move of the selected counter toward the resolved outcome.
  always_comb begin
    cnt_next = cnt_cur;
    if (branch) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  // New outcome enters at the LSB; the oldest outcome falls off the MSB.
  always_comb begin
    ghr_next = {ghr_reg[HIST_BITS-2:0], branch};
  end

  // History register: cleared by reset, shifted on every training strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_reg <= '0;
    end else if (update) begin
      ghr_reg <= ghr_next;
    end
  end

  // One register per table entry so the whole table can be reset to weakly
  // not-taken in a single cycle; only the entry at the old GHR is written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pht
      // Counter entry gi: reset to weak NT, trained when it is the indexed entry.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pht_reg[gi] <= 2'b01;
        end else if (update && (ghr_reg == HIST_BITS'(gi))) begin
          pht_reg[gi] <= cnt_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_global_branch_predictor.sv
// Bench for global_branch_predictor: a table of directed vectors covering the
// reset, training, saturation, idle, alternating and reset-priority cases,
// followed by randomized traffic compared against a behavioural model.
module tb_global_branch_predictor;

  logic clk;
  logic rst_n;
  logic branch;
  logic update;
  logic prediction;

  int total;
  int bad;

  // Behavioural model: history as an integer, counters as integers 0..3.
  int hist_m;
  int ctr_m [16];

  typedef struct {
    logic  rst_n;
    logic  update;
    logic  branch;
    logic  exp_pred;
    string name;
  } vec_t;

  vec_t vecs [64];
  int   nvec;

  global_branch_predictor #(.HIST_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .branch    (branch),
    .update    (update),
    .prediction(prediction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic u, input logic b);
    int c;
    if (!r) begin
      hist_m = 0;
      for (int i = 0; i < 16; i++) ctr_m[i] = 1;
    end else if (u) begin
      c = ctr_m[hist_m];
      if (b) c = (c == 3) ? 3 : c + 1;
      else   c = (c == 0) ? 0 : c - 1;
      ctr_m[hist_m] = c;
      hist_m = ((hist_m * 2) + (b ? 1 : 0)) % 16;
    end
  endtask

  function automatic logic model_pred();
    return (ctr_m[hist_m] >= 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string name, input logic exp);
    total++;
    if (prediction !== exp) begin
      bad++;
      $display("FAIL %s: prediction=%b expected=%b", name, prediction, exp);
    end else begin
      $display("ok   %s: prediction=%b", name, prediction);
    end
  endtask

  // Apply one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic u, input logic b);
    rst_n  = r;
    update = u;
    branch = b;
    @(posedge clk);
    #1;
    model_step(r, u, b);
  endtask

  task automatic add(input logic r, input logic u, input logic b,
                     input logic e, input string n);
    vecs[nvec].rst_n    = r;
    vecs[nvec].update   = u;
    vecs[nvec].branch   = b;
    vecs[nvec].exp_pred = e;
    vecs[nvec].name     = n;
    nvec++;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    nvec   = 0;
    hist_m = 0;
    for (int i = 0; i < 16; i++) ctr_m[i] = 1;
    rst_n  = 1'b0;
    update = 1'b0;
    branch = 1'b0;

    // Reset, five taken updates, saturation at index 15, then not-taken.
    add(0, 0, 0, 0, "reset");
    add(1, 1, 1, 0, "t1_ghr0001");
    add(1, 1, 1, 0, "t2_ghr0011");
    add(1, 1, 1, 0, "t3_ghr0111");
    add(1, 1, 1, 0, "t4_ghr1111_weakNT");
    add(1, 1, 1, 1, "t5_pht15_weakT");
    add(1, 1, 1, 1, "t6_pht15_strongT");
    add(1, 1, 1, 1, "t7_pht15_saturated");
    add(1, 1, 0, 0, "n8_ghr1110_pht14");
    // Idle with branch toggling: nothing may change.
    for (int i = 0; i < 10; i++) add(1, 0, 1'(i % 2), 0, "idle");
    // One taken: history 1101 (weak NT), then 1011.
    add(1, 1, 1, 0, "after_idle_ghr1101");
    // Alternating T,N from reset.
    add(0, 0, 0, 0, "reset_alt");
    add(1, 1, 1, 0, "alt1_ghr0001");
    add(1, 1, 0, 0, "alt2_ghr0010");
    add(1, 1, 1, 0, "alt3_ghr0101");
    add(1, 1, 0, 0, "alt4_ghr1010_weakNT");
    add(1, 1, 1, 0, "alt5_ghr0101_strongNT");
    for (int i = 6; i <= 16; i++)
      add(1, 1, 1'(i % 2), (i % 2 == 0) ? 1'b1 : 1'b0, "alt_tail");
    // Reset mid-training with a simultaneous taken update: reset wins.
    add(0, 0, 0, 0, "reset_pre6");
    for (int i = 0; i < 5; i++) add(1, 1, 1, (i == 4) ? 1'b1 : 1'b0, "s6_taken");
    add(0, 1, 1, 0, "reset_beats_update");
    add(1, 1, 1, 0, "post_reset_ghr0001");

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].rst_n, vecs[i].update, vecs[i].branch);
      check(vecs[i].name, vecs[i].exp_pred);
    end

    // Hand sequence: prediction is combinational and holds between edges.
    step(0, 0, 0);
    repeat (5) step(1, 1, 1);
    check("hold_before", 1'b1);
    update = 1'b0;
    branch = 1'b0;
    #3;
    check("hold_mid_cycle", 1'b1);

    // Randomized traffic against the model, with occasional resets.
    step(0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic r, u, b;
      r = ($urandom_range(0, 99) != 0);
      u = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 9) < 7);
      step(r, u, b);
      total++;
      if (prediction !== model_pred()) begin
        bad++;
        $display("FAIL rand[%0d]: prediction=%b expected=%b (rst_n=%b update=%b branch=%b)",
                 i, prediction, model_pred(), r, u, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
